output_drain_ctrl: RTL and testbench
====================================

Name: output_drain_ctrl

Overview:
Controller in front of the 32-entry output register. It shares the register's single index port between CPU writes from the accumulator path and a drain engine. The drain engine streams a selected index range to an external valid/ready sink, one byte at a time. It sits between the CPU execute stage, the output register and the external output interface.

Parameters:
DEPTH, 32, number of output register entries (power of two)
IDX_W, 5, index width, log2(DEPTH)
DATA_W, 8, entry width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cpu_wr_req  in  1  CPU requests a write of cpu_wr_data to cpu_wr_index
cpu_wr_index  in  IDX_W  CPU write index
cpu_wr_data  in  DATA_W  accumulator value to store
cpu_wr_ack  out  1  write accepted this cycle (combinational, equals cpu_wr_req)
drain_start  in  1  start drain of range first..last (pulse)
drain_first  in  IDX_W  first index to drain
drain_last  in  IDX_W  last index to drain (inclusive)
drain_busy  out  1  drain in progress
drain_done  out  1  one-cycle pulse after the last byte is accepted
out_valid  out  1  out_data/out_index valid toward sink
out_ready  in  1  sink accepts
out_data  out  DATA_W  drained byte (registered)
out_index  out  IDX_W  index of drained byte (registered)
reg_write_enable  out  1  to output register write enable
reg_read_enable  out  1  to output register read enable
reg_index  out  IDX_W  to output register index
reg_wdata  out  DATA_W  to output register write data
reg_rdata  in  DATA_W  combinational read data from output register

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; drain_busy, drain_done, out_valid = 0; out_data, out_index, ptr, last_q = 0. Register contents are untouched. Reset mid-drain aborts without a drain_done pulse.
- Arbitration is fixed priority, CPU over drain.
  - cpu_wr_req=1: reg_write_enable=1, reg_index=cpu_wr_index, reg_wdata=cpu_wr_data, reg_read_enable=0.
  - Writes complete at that edge; cpu_wr_ack=cpu_wr_req. The CPU never stalls.
  - Otherwise reg_index=ptr and reg_wdata=0. reg_read_enable=1 only in READ.
- FSM states: IDLE, READ, SEND, DONE.
  - IDLE: on drain_start, capture ptr<=drain_first and last_q<=drain_last, then go to READ. drain_busy=1 from the next cycle.
  - READ: if cpu_wr_req, stall in READ and do not read. Else reg_read_enable=1; at the edge, out_data<=reg_rdata and out_index<=ptr, go to SEND.
  - SEND: out_valid=1. out_data/out_index hold stable while out_ready=0.
  - SEND on out_ready=1: if ptr==last_q, go to DONE. Else ptr<=ptr+1 modulo DEPTH (31 wraps to 0), go to READ.
  - DONE: drain_done=1 for exactly one cycle, drain_busy=0, go to IDLE.
- drain_start is ignored while not in IDLE.
- Range arithmetic: byte count = ((drain_last - drain_first) mod DEPTH) + 1.
  - first==last drains 1 byte.
  - first>last wraps through 31 to 0; e.g. 30..1 drains 30, 31, 0, 1.
- Latency: drain_start at cycle 0 gives READ at cycle 1 and out_valid at cycle 2 (no contention, sink ready). Steady throughput is 1 byte per 2 cycles.
- Snapshot semantics: out_data is captured at read time. A later CPU write to the same index does not alter a byte already in SEND. A CPU write in the stalled READ cycle is visible to the read in the next cycle.
- A CPU write during SEND proceeds normally; out_valid is unaffected.

Decomposition:
- Shared package: DEPTH/IDX_W/DATA_W constants and the drain state enum (IDLE, READ, SEND, DONE). The output register port bundle widths also go there.
- No sub-module; the arbiter mux and the FSM live in one module.
- Top level instantiates output_drain_ctrl alongside the existing output register.

Test Plan:
- Preload idx 3..5 = 0x11, 0x22, 0x33. Start first=3, last=5 with out_ready=1 -> out_valid beats at cycles 2, 4, 6 with data 0x11, 0x22, 0x33 and indices 3, 4, 5; drain_done pulses at cycle 7.
- Wrap: preload 30=0xA0, 31=0xA1, 0=0xA2, 1=0xA3; drain 30..1 -> four beats in order 30, 31, 0, 1 with matching data; done once.
- Contention: during READ of idx 4, assert cpu_wr_req idx 4 data 0x5A for 2 cycles -> cpu_wr_ack=1 both cycles, READ stalls 2 cycles, drained byte = 0x5A.
- Backpressure: hold out_ready=0 for 5 cycles in SEND, then write 0xFF to the current index -> out_data stays stable at the original value, and the index advances only after ready.
- Ignored start plus single entry: drain 7..7 -> exactly 1 beat. A drain_start pulsed during SEND has no effect.
- Reset mid-drain: assert rst during SEND -> next cycle out_valid=0, drain_busy=0, no drain_done; register contents are intact on a new drain.

Source files
------------

// File: rtl/output_drain_ctrl_pkg.sv
// output_drain_ctrl_pkg: shared sizes, index/data types and drain state encoding
package output_drain_ctrl_pkg;
  localparam int DEPTH  = 32;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int DATA_W = 8;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} drain_state_t;
endpackage

// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl: CPU-priority index port arbiter and range drain engine for the output register
module output_drain_ctrl
  import output_drain_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  cpu_wr_req,
  input  idx_t  cpu_wr_index,
  input  data_t cpu_wr_data,
  output logic  cpu_wr_ack,
  input  logic  drain_start,
  input  idx_t  drain_first,
  input  idx_t  drain_last,
  output logic  drain_busy,
  output logic  drain_done,
  output logic  out_valid,
  input  logic  out_ready,
  output data_t out_data,
  output idx_t  out_index,
  output logic  reg_write_enable,
  output logic  reg_read_enable,
  output idx_t  reg_index,
  output data_t reg_wdata,
  input  data_t reg_rdata
);
  drain_state_t state, nxt;
  idx_t ptr, last_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      last_q    <= '0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && drain_start) begin
        ptr    <= drain_first;
        last_q <= drain_last;
      end
      if (state == READ && !cpu_wr_req) begin
        out_data  <= reg_rdata;
        out_index <= ptr;
      end
      if (state == SEND && out_ready && ptr != last_q) ptr <= ptr + 1'b1;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (drain_start ? READ : IDLE) :
          state == READ ? (cpu_wr_req ? READ : SEND) :
          state == SEND ? (out_ready ? (ptr == last_q ? DONE : READ) : SEND) :
          IDLE;
    cpu_wr_ack       = cpu_wr_req;
    reg_write_enable = cpu_wr_req;
    reg_read_enable  = state == READ && !cpu_wr_req;
    reg_index        = cpu_wr_req ? cpu_wr_index : ptr;
    reg_wdata        = cpu_wr_req ? cpu_wr_data : '0;
    drain_busy       = state == READ || state == SEND;
    drain_done       = state == DONE;
    out_valid        = state == SEND;
  end
endmodule

// File: tb/tb_output_drain_ctrl.sv
// tb_output_drain_ctrl: table-driven and directed checks of the output drain controller
module tb_output_drain_ctrl;
  logic       clk, rst;
  logic       cpu_wr_req, cpu_wr_ack;
  logic [4:0] cpu_wr_index;
  logic [7:0] cpu_wr_data;
  logic       drain_start, drain_busy, drain_done;
  logic [4:0] drain_first, drain_last;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [4:0] out_index;
  logic       reg_write_enable, reg_read_enable;
  logic [4:0] reg_index;
  logic [7:0] reg_wdata, reg_rdata;
  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;
  logic [4:0] got_idx[$];
  logic [7:0] got_dat[$];
  int dones;
  output_drain_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_index(cpu_wr_index), .cpu_wr_data(cpu_wr_data), .cpu_wr_ack(cpu_wr_ack),
    .drain_start(drain_start), .drain_first(drain_first), .drain_last(drain_last),
    .drain_busy(drain_busy), .drain_done(drain_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .reg_write_enable(reg_write_enable), .reg_read_enable(reg_read_enable),
    .reg_index(reg_index), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (reg_write_enable) mem[reg_index] <= reg_wdata;
  assign reg_rdata = mem[reg_index];
  typedef struct {
    logic req; logic [4:0] widx; logic [7:0] wdata;
    logic start; logic [4:0] first; logic [4:0] last; logic rdy;
    logic busy; logic done; logic valid; logic [7:0] odata; logic [4:0] oidx; logic re; logic [4:0] ridx;
  } vec_t;
  vec_t vt[$];
  function automatic vec_t mk(input logic req, input logic [4:0] widx, input logic [7:0] wdata,
                              input logic start, input logic [4:0] first, input logic [4:0] last, input logic rdy,
                              input logic busy, input logic done, input logic valid,
                              input logic [7:0] odata, input logic [4:0] oidx, input logic re, input logic [4:0] ridx);
    vec_t v;
    v.req = req; v.widx = widx; v.wdata = wdata; v.start = start; v.first = first; v.last = last; v.rdy = rdy;
    v.busy = busy; v.done = done; v.valid = valid; v.odata = odata; v.oidx = oidx; v.re = re; v.ridx = ridx;
    return v;
  endfunction
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [4:0] idx, input logic [7:0] d);
    cpu_wr_req = 1; cpu_wr_index = idx; cpu_wr_data = d;
    #1;
    chk("wr_ack", {31'd0, cpu_wr_ack}, 32'd1);
    tick();
    cpu_wr_req = 0;
  endtask
  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask
  task automatic run_collect(input logic [4:0] first, input logic [4:0] last, input int cycles);
    got_idx.delete(); got_dat.delete(); dones = 0;
    drain_start = 1; drain_first = first; drain_last = last; out_ready = 1;
    #1;
    tick();
    drain_start = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      if (out_valid && out_ready) begin got_idx.push_back(out_index); got_dat.push_back(out_data); end
      if (drain_done) dones++;
      tick();
    end
  endtask
  initial begin
    logic [4:0] ei[4];
    logic [7:0] ed[4];
    rst = 1; cpu_wr_req = 0; cpu_wr_index = 0; cpu_wr_data = 0;
    drain_start = 0; drain_first = 0; drain_last = 0; out_ready = 0;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_busy", {31'd0, drain_busy}, 0);
    chk("rst_done", {31'd0, drain_done}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_out", {19'd0, out_index, out_data}, 0);
    chk("rst_ridx", {27'd0, reg_index}, 0);
    vt.push_back(mk(1,3,8'h11,0,0,0,1, 0,0,0,8'h00,0,0,3));
    vt.push_back(mk(1,4,8'h22,0,0,0,1, 0,0,0,8'h00,0,0,4));
    vt.push_back(mk(1,5,8'h33,0,0,0,1, 0,0,0,8'h00,0,0,5));
    vt.push_back(mk(0,0,8'h00,1,3,5,1, 0,0,0,8'h00,0,0,0));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,0,8'h00,0,1,3));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,1,8'h11,3,0,3));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,0,8'h11,3,1,4));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,1,8'h22,4,0,4));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,0,8'h22,4,1,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,1,8'h33,5,0,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 0,1,0,8'h33,5,0,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,0,8'h33,5,0,5));
    vt.push_back(mk(0,0,8'h00,1,3,5,1, 0,0,0,8'h33,5,0,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,0,8'h33,5,1,3));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,1,8'h11,3,0,3));
    vt.push_back(mk(1,4,8'h5A,0,0,0,1, 1,0,0,8'h11,3,0,4));
    vt.push_back(mk(1,4,8'h5A,0,0,0,1, 1,0,0,8'h11,3,0,4));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,0,8'h11,3,1,4));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,1,8'h5A,4,0,4));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,0,8'h5A,4,1,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,1,8'h33,5,0,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 0,1,0,8'h33,5,0,5));
    vt.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,0,8'h33,5,0,5));
    foreach (vt[i]) begin
      cpu_wr_req = vt[i].req; cpu_wr_index = vt[i].widx; cpu_wr_data = vt[i].wdata;
      drain_start = vt[i].start; drain_first = vt[i].first; drain_last = vt[i].last; out_ready = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {cpu_wr_ack, reg_write_enable, reg_read_enable, drain_busy, drain_done, out_valid, reg_index, out_index, out_data, reg_wdata},
          {vt[i].req, vt[i].req, vt[i].re, vt[i].busy, vt[i].done, vt[i].valid, vt[i].ridx, vt[i].oidx, vt[i].odata,
           vt[i].req ? vt[i].wdata : 8'h00});
      tick();
    end
    cpu_wr_req = 0; drain_start = 0;
    wr(30, 8'hA0); wr(31, 8'hA1); wr(0, 8'hA2); wr(1, 8'hA3);
    run_collect(30, 1, 14);
    ei = '{30, 31, 0, 1};
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    chk("wrap_beats", got_idx.size(), 4);
    chk("wrap_done", dones, 1);
    for (int i = 0; i < 4 && i < got_idx.size(); i++)
      chk($sformatf("wrap_beat%0d", i), {19'd0, got_idx[i], got_dat[i]}, {19'd0, ei[i], ed[i]});
    wr(6, 8'h66); wr(7, 8'h77);
    drain_start = 1; drain_first = 6; drain_last = 7; out_ready = 0;
    #1;
    tick();
    drain_start = 0;
    wait_valid("bp_valid");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {18'd0, out_valid, out_index, out_data}, {18'd0, 1'b1, 5'd6, 8'h66});
      tick();
    end
    cpu_wr_req = 1; cpu_wr_index = 6; cpu_wr_data = 8'hFF;
    #1;
    chk("bp_wr_send", {17'd0, cpu_wr_ack, out_valid, out_index, out_data}, {17'd0, 1'b1, 1'b1, 5'd6, 8'h66});
    tick();
    cpu_wr_req = 0;
    #1;
    chk("bp_after_wr", {18'd0, out_valid, out_index, out_data}, {18'd0, 1'b1, 5'd6, 8'h66});
    out_ready = 1;
    tick();
    chk("bp_adv", {18'd0, out_valid, out_index, reg_index, 3'd0}, {18'd0, 1'b0, 5'd6, 5'd7, 3'd0});
    tick();
    chk("bp_next", {18'd0, out_valid, out_index, out_data}, {18'd0, 1'b1, 5'd7, 8'h77});
    tick();
    chk("bp_done", {30'd0, drain_done, drain_busy}, 32'd2);
    tick();
    out_ready = 0;
    drain_start = 1; drain_first = 7; drain_last = 7;
    #1;
    tick();
    drain_start = 0;
    wait_valid("one_valid");
    drain_start = 1; drain_first = 0; drain_last = 3;
    #1;
    tick();
    drain_start = 0; out_ready = 1;
    got_idx.delete(); got_dat.delete(); dones = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid && out_ready) begin got_idx.push_back(out_index); got_dat.push_back(out_data); end
      if (drain_done) dones++;
      tick();
    end
    chk("one_beats", got_idx.size(), 1);
    chk("one_done", dones, 1);
    if (got_idx.size() > 0) chk("one_beat", {19'd0, got_idx[0], got_dat[0]}, {19'd0, 5'd7, 8'h77});
    chk("one_idle", {31'd0, drain_busy}, 0);
    out_ready = 0;
    drain_start = 1; drain_first = 3; drain_last = 5;
    #1;
    tick();
    drain_start = 0;
    wait_valid("rst_mid_valid");
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_mid", {16'd0, out_valid, drain_busy, drain_done, out_index, out_data},
        {16'd0, 3'b000, 5'd0, 8'h00});
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (drain_done || drain_busy) dones++;
      tick();
    end
    chk("rst_mid_quiet", dones, 0);
    run_collect(3, 5, 10);
    ei = '{3, 4, 5, 0};
    ed = '{8'h11, 8'h5A, 8'h33, 8'h00};
    chk("again_beats", got_idx.size(), 3);
    chk("again_done", dones, 1);
    for (int i = 0; i < 3 && i < got_idx.size(); i++)
      chk($sformatf("again_beat%0d", i), {19'd0, got_idx[i], got_dat[i]}, {19'd0, ei[i], ed[i]});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
